// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequencer for a streaming MxM-kernel convolution engine over
// an NxN image. Pulls M*M kernel words then N*N image words (raster order)
// from a valid/ready source, forwards each accepted word to the engine with a
// shift strobe, and produces the per-result valid plus output-map coordinates
// through a LAT-deep delay pipe that matches the engine latency.
//
// Ports:
//   clock      rising-edge clock
//   rst        asynchronous active-high reset
//   start      begin one job (sampled only while idle)
//   abort      cancel the current job, effective next cycle
//   src_valid  source word available
//   src_data   source word
//   src_ready  controller accepts src_data this cycle
//   eng_a_in   word forwarded to the engine
//   eng_shift  engine consumes eng_a_in this cycle
//   eng_kload  shift carries a kernel word
//   eng_clr    one-cycle engine clear
//   out_valid  engine result valid this cycle
//   out_row    output-map row of the current result
//   out_col    output-map column of the current result
//   busy       job in progress
//   done       one-cycle completion pulse
module conv_seq_ctrl #(
    parameter int unsigned N   = 3,
    parameter int unsigned M   = 2,
    parameter int unsigned DW  = 32,
    parameter int unsigned LAT = 1
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    output logic          src_ready,
    output logic [DW-1:0] eng_a_in,
    output logic          eng_shift,
    output logic          eng_kload,
    output logic          eng_clr,
    output logic          out_valid,
    output logic [(((N-M+1) > 1) ? $clog2(N-M+1) : 1)-1:0] out_row,
    output logic [(((N-M+1) > 1) ? $clog2(N-M+1) : 1)-1:0] out_col,
    output logic          busy,
    output logic          done
);

    localparam int unsigned OW  = ((N - M + 1) > 1) ? $clog2(N - M + 1) : 1;
    localparam int unsigned KW  = $clog2(M * M + 1);
    localparam int unsigned RW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned DCW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_K,
        S_LOAD_I,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   kcnt_q;
    logic [RW-1:0]   r_q, c_q;
    logic [DCW-1:0]  dcnt_q;
    logic            clr_q;

    logic            loading;
    logic            xfer;
    logic            abort_act;
    logic            last_k;
    logic            last_i;
    logic            hit;
    logic [OW-1:0]   hit_row, hit_col;

    // Handshake, hit detection and next-state logic
    always_comb begin
        state_d   = state_q;
        loading   = (state_q == S_LOAD_K) || (state_q == S_LOAD_I);
        abort_act = abort && (state_q != S_IDLE);
        xfer      = loading && src_valid;
        src_ready = loading;
        eng_shift = xfer;
        eng_a_in  = loading ? src_data : '0;
        eng_kload = (state_q == S_LOAD_K) && xfer;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        // Start clear is combinational on the IDLE->LOAD_K cycle; abort clear
        // is registered so it lands on the first IDLE cycle after the abort.
        eng_clr   = clr_q || ((state_q == S_IDLE) && start && !abort);
        last_k    = (kcnt_q == KW'(M * M - 1));
        last_i    = (r_q == RW'(N - 1)) && (c_q == RW'(N - 1));
        hit       = xfer && !abort && (state_q == S_LOAD_I) &&
                    (r_q >= RW'(M - 1)) && (c_q >= RW'(M - 1));
        hit_row   = hit ? OW'(r_q - RW'(M - 1)) : '0;
        hit_col   = hit ? OW'(c_q - RW'(M - 1)) : '0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) state_d = S_LOAD_K;
            end
            S_LOAD_K: begin
                if (xfer && last_k) state_d = S_LOAD_I;
            end
            S_LOAD_I: begin
                if (xfer && last_i) state_d = (LAT == 0) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (dcnt_q == DCW'((LAT > 0) ? LAT - 1 : 0)) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_act) state_d = S_IDLE;
    end

    // State register and position counters
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            kcnt_q  <= '0;
            r_q     <= '0;
            c_q     <= '0;
            dcnt_q  <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= abort_act;
            if (abort_act) begin
                kcnt_q <= '0;
                r_q    <= '0;
                c_q    <= '0;
                dcnt_q <= '0;
            end else begin
                if ((state_q == S_LOAD_K) && xfer) begin
                    kcnt_q <= last_k ? '0 : kcnt_q + KW'(1);
                end
                if ((state_q == S_LOAD_I) && xfer) begin
                    if (c_q == RW'(N - 1)) begin
                        c_q <= '0;
                        r_q <= (r_q == RW'(N - 1)) ? '0 : r_q + RW'(1);
                    end else begin
                        c_q <= c_q + RW'(1);
                    end
                end
                dcnt_q <= (state_q == S_DRAIN) ? dcnt_q + DCW'(1) : '0;
            end
        end
    end

    // Delay pipe aligning hit/coordinates with the engine result
    generate
        if (LAT == 0) begin : g_nopipe
            assign out_valid = hit;
            assign out_row   = hit_row;
            assign out_col   = hit_col;
        end else begin : g_pipe
            logic          pv   [LAT];
            logic [OW-1:0] prow [LAT];
            logic [OW-1:0] pcol [LAT];

            always_ff @(posedge clock or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < int'(LAT); i++) begin
                        pv[i]   <= 1'b0;
                        prow[i] <= '0;
                        pcol[i] <= '0;
                    end
                end else if (abort_act) begin
                    for (int i = 0; i < int'(LAT); i++) begin
                        pv[i]   <= 1'b0;
                        prow[i] <= '0;
                        pcol[i] <= '0;
                    end
                end else begin
                    pv[0]   <= hit;
                    prow[0] <= hit_row;
                    pcol[0] <= hit_col;
                    for (int i = 1; i < int'(LAT); i++) begin
                        pv[i]   <= pv[i-1];
                        prow[i] <= prow[i-1];
                        pcol[i] <= pcol[i-1];
                    end
                end
            end

            assign out_valid = pv[LAT-1];
            assign out_row   = prow[LAT-1];
            assign out_col   = pcol[LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: N=3/M=2/LAT=1 instance for the main
// scenarios plus an N=4/M=4/LAT=0 instance for the single-output case.
module tb_conv_seq_ctrl;

    logic        clock;
    logic        rst;
    logic        start, abort, src_valid;
    logic [31:0] src_data;
    logic        src_ready, eng_shift, eng_kload, eng_clr, out_valid, busy, done;
    logic [31:0] eng_a_in;
    logic [0:0]  out_row, out_col;

    logic        s6_start, s6_abort, s6_valid;
    logic [31:0] s6_data;
    logic        s6_ready, s6_shift, s6_kload, s6_clr, s6_ov, s6_busy, s6_done;
    logic [31:0] s6_a_in;
    logic [0:0]  s6_row, s6_col;

    int total = 0;
    int bad   = 0;

    logic [63:0] m_ov, m_done, m_busy, m_kload, m_shift, m_clr, seq;
    int          n_ov, a_bad;

    conv_seq_ctrl #(.N(3), .M(2), .DW(32), .LAT(1)) u_dut (
        .clock(clock), .rst(rst), .start(start), .abort(abort),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .eng_a_in(eng_a_in), .eng_shift(eng_shift), .eng_kload(eng_kload),
        .eng_clr(eng_clr), .out_valid(out_valid), .out_row(out_row),
        .out_col(out_col), .busy(busy), .done(done)
    );

    conv_seq_ctrl #(.N(4), .M(4), .DW(32), .LAT(0)) u_dut6 (
        .clock(clock), .rst(rst), .start(s6_start), .abort(s6_abort),
        .src_valid(s6_valid), .src_data(s6_data), .src_ready(s6_ready),
        .eng_a_in(s6_a_in), .eng_shift(s6_shift), .eng_kload(s6_kload),
        .eng_clr(s6_clr), .out_valid(s6_ov), .out_row(s6_row),
        .out_col(s6_col), .busy(s6_busy), .done(s6_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_rec();
        m_ov = '0; m_done = '0; m_busy = '0; m_kload = '0;
        m_shift = '0; m_clr = '0; seq = '0; n_ov = 0; a_bad = 0;
    endtask

    // Runs ncyc cycles on u_dut; cycle 0 carries the start pulse
    task automatic run_job(input int ncyc, input bit toggle, input int start2, input int abort_cyc);
        clear_rec();
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clock);
            start     = (cyc == 0) || (cyc == start2);
            abort     = (cyc == abort_cyc);
            src_valid = toggle ? cyc[0] : 1'b1;
            src_data  = 32'hA000 + 32'(cyc);
            #1;
            if (out_valid) begin
                m_ov = m_ov | (64'd1 << cyc);
                seq  = (seq << 2) | 64'({out_row, out_col});
                n_ov++;
            end
            if (done)      m_done  = m_done  | (64'd1 << cyc);
            if (busy)      m_busy  = m_busy  | (64'd1 << cyc);
            if (eng_kload) m_kload = m_kload | (64'd1 << cyc);
            if (eng_shift) m_shift = m_shift | (64'd1 << cyc);
            if (eng_clr)   m_clr   = m_clr   | (64'd1 << cyc);
            if (eng_shift && (eng_a_in !== src_data)) a_bad++;
        end
        start = 1'b0; abort = 1'b0; src_valid = 1'b0;
    endtask

    task automatic check_job(input string s, input logic [63:0] e_ov, input logic [63:0] e_done,
                             input logic [63:0] e_busy, input logic [63:0] e_kload,
                             input logic [63:0] e_shift, input logic [63:0] e_clr,
                             input logic [63:0] e_seq, input int e_n);
        check({s, ".out_valid"}, m_ov, e_ov);
        check({s, ".done"},      m_done, e_done);
        check({s, ".busy"},      m_busy, e_busy);
        check({s, ".kload"},     m_kload, e_kload);
        check({s, ".shift"},     m_shift, e_shift);
        check({s, ".clr"},       m_clr, e_clr);
        check({s, ".coords"},    seq, e_seq);
        check({s, ".n_out"},     64'(n_ov), 64'(e_n));
        check({s, ".a_in"},      64'(a_bad), 64'd0);
    endtask

    initial begin
        logic [63:0] idle_acc;
        rst = 1'b1; start = 1'b0; abort = 1'b0; src_valid = 1'b0; src_data = 32'hDEAD;
        s6_start = 1'b0; s6_abort = 1'b0; s6_valid = 1'b0; s6_data = '0;
        #2;
        check("reset.busy_done", 64'({busy, done}), 64'd0);
        check("reset.ready_shift", 64'({src_ready, eng_shift, eng_kload, eng_clr}), 64'd0);
        check("reset.out", 64'({out_valid, out_row, out_col}), 64'd0);
        check("reset.a_in", 64'(eng_a_in), 64'd0);
        @(negedge clock);
        rst = 1'b0;

        // 1: continuous source
        run_job(17, 1'b0, -1, -1);
        check_job("s1", 64'h6C00, 64'h8000, 64'hFFFE, 64'h1E, 64'h3FFE, 64'h1, 64'h1B, 4);

        // 2: source valid only on odd cycles
        run_job(30, 1'b1, -1, -1);
        check_job("s2", 64'h0514_0000, 64'h0800_0000, 64'h0FFF_FFFE, 64'hAA,
                  64'h02AA_AAAA, 64'h1, 64'h1B, 4);

        // 3: abort in the cycle after the 6th transfer, then a clean job
        run_job(20, 1'b0, -1, 7);
        check_job("s3a", 64'h0, 64'h0, 64'hFE, 64'h1E, 64'hFE, 64'h101, 64'h0, 0);
        run_job(17, 1'b0, -1, -1);
        check_job("s3b", 64'h6C00, 64'h8000, 64'hFFFE, 64'h1E, 64'h3FFE, 64'h1, 64'h1B, 4);

        // 4: second start during LOAD_I is ignored
        run_job(17, 1'b0, 7, -1);
        check_job("s4", 64'h6C00, 64'h8000, 64'hFFFE, 64'h1E, 64'h3FFE, 64'h1, 64'h1B, 4);

        // 5: async reset while result (1,0) is on the outputs
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clock);
            start     = (cyc == 0);
            src_valid = 1'b1;
            src_data  = 32'hB000 + 32'(cyc);
            #1;
        end
        check("s5.pre", 64'({busy, out_valid, out_row, out_col}), 64'b1110);
        rst = 1'b1;
        #1;
        check("s5.busy_done", 64'({busy, done}), 64'd0);
        check("s5.ready_shift", 64'({src_ready, eng_shift, eng_kload, eng_clr}), 64'd0);
        check("s5.out", 64'({out_valid, out_row, out_col}), 64'd0);
        check("s5.a_in", 64'(eng_a_in), 64'd0);
        @(negedge clock);
        rst = 1'b0;
        idle_acc = '0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clock);
            #1;
            idle_acc = idle_acc | 64'({busy, eng_shift, out_valid, done});
        end
        check("s5.idle", idle_acc, 64'd0);
        src_valid = 1'b0;

        // 6: N=4, M=4, LAT=0 single result
        clear_rec();
        for (int cyc = 0; cyc < 36; cyc++) begin
            @(negedge clock);
            s6_start = (cyc == 0);
            s6_valid = 1'b1;
            s6_data  = 32'hC000 + 32'(cyc);
            #1;
            if (s6_ov) begin
                m_ov = m_ov | (64'd1 << cyc);
                seq  = (seq << 2) | 64'({s6_row, s6_col});
                n_ov++;
            end
            if (s6_done)  m_done  = m_done  | (64'd1 << cyc);
            if (s6_busy)  m_busy  = m_busy  | (64'd1 << cyc);
            if (s6_kload) m_kload = m_kload | (64'd1 << cyc);
            if (s6_shift) m_shift = m_shift | (64'd1 << cyc);
            if (s6_clr)   m_clr   = m_clr   | (64'd1 << cyc);
            if (s6_shift && (s6_a_in !== s6_data)) a_bad++;
        end
        s6_start = 1'b0; s6_valid = 1'b0;
        check_job("s6", 64'h1_0000_0000, 64'h2_0000_0000, 64'h3_FFFF_FFFE, 64'h1_FFFE,
                  64'h1_FFFF_FFFE, 64'h1, 64'h0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
- Sequencer for the streaming M×M-kernel convolution engine over an N×N image.
- Takes a start command and pulls M*M kernel words, then N*N image words (raster order), from a valid/ready source.
- Forwards each accepted word to the engine with a shift strobe; the engine holds its state when the strobe is low.
- Generates the engine's per-result valid, the output-map coordinates, and busy/done status, replacing free-running counters with an explicit, stall-tolerant FSM.

Parameters:
- N, 3, image side length; requires M <= N.
- M, 2, kernel side length; M >= 1.
- DW, 32, data word width.
- LAT, 1, engine latency: cycles from a shift strobe to the matching result. LAT >= 0.

Ports:
- clock  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin one convolution; sampled only in IDLE.
- abort  in  1  cancel the current job; takes effect the next cycle.
- src_valid  in  1  source word available.
- src_data  in  DW  source word.
- src_ready  out  1  controller accepts src_data this cycle.
- eng_a_in  out  DW  word forwarded to the engine.
- eng_shift  out  1  engine consumes eng_a_in this cycle.
- eng_kload  out  1  high with eng_shift while kernel words are streamed.
- eng_clr  out  1  one-cycle engine clear.
- out_valid  out  1  engine result is valid this cycle.
- out_row  out  clog2(N-M+1) (min 1)  output-map row of the current result.
- out_col  out  clog2(N-M+1) (min 1)  output-map column of the current result.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at job completion.

Behaviour:
- Reset (async): state=IDLE, all counters 0, delay pipe cleared. Every output is 0, including out_row, out_col and eng_a_in.
- FSM states: IDLE, LOAD_K, LOAD_I, DRAIN, DONE.
- IDLE:
  - start=1 -> LOAD_K and eng_clr=1 for that one transition cycle.
  - start=0, or start together with abort -> remain in IDLE.
- Handshake (LOAD_K/LOAD_I only):
  - src_ready=1 combinationally in these states.
  - Transfer occurs when src_valid & src_ready.
  - eng_shift = transfer; eng_a_in = src_data (combinational pass-through).
  - No transfer -> eng_shift=0 and the engine holds.
- LOAD_K:
  - eng_kload = transfer.
  - kcnt counts transfers; on the (M*M)th transfer -> LOAD_I.
- LOAD_I:
  - Row/column counters r,c track the position of the word being transferred; c wraps at N-1 and increments r.
  - A transfer is a window hit iff r >= M-1 and c >= M-1.
  - On the transfer with r=N-1, c=N-1 -> DRAIN.
- Delay pipe:
  - LAT-deep shift register carrying {hit, r-(M-1), c-(M-1)}; it advances every cycle regardless of stalls.
  - out_valid/out_row/out_col = pipe output. When LAT=0 they are combinational from the current transfer.
  - When out_valid=0, out_row/out_col are 0.
- DRAIN: waits LAT cycles (zero cycles if LAT=0), then -> DONE.
- DONE: done=1 for one cycle, then -> IDLE.
- busy=1 in LOAD_K, LOAD_I, DRAIN and DONE.
- start while busy: ignored, no effect.
- abort in any non-IDLE state:
  - Next state IDLE; counters are zeroed and pipe valids are cleared, so no further out_valid appears.
  - eng_clr=1 for one cycle on the abort transition; done is NOT pulsed.
  - abort and the final transfer in the same cycle: abort wins.
- Output count per job: exactly (N-M+1)^2 out_valid pulses, in raster order of the output map.
- Stalls (src_valid low) may occur at any point, including mid-row, between kernel and image, and on the last word. A stall never produces or drops an out_valid.
- Counter widths: clog2(M*M+1) for kcnt, clog2(N) for r and c, clog2(LAT+1) for the drain counter. No wrap beyond the stated bounds.

Test Plan:
1. N=3, M=2, LAT=1, src_valid held high, start pulse at cycle 0.
   - 13 transfers in cycles 1–13; eng_kload high in cycles 1–4.
   - out_valid in cycles 10, 11, 13, 14 with (row,col) = (0,0), (0,1), (1,0), (1,1).
   - done in cycle 15; busy high in cycles 1–15.
2. Same as scenario 1 with src_valid deasserted every other cycle.
   - Still exactly 4 out_valid with the same coordinate order.
   - Each out_valid occurs 1 cycle after its hit transfer; done occurs 2 cycles after the last transfer.
3. abort asserted after the 6th transfer.
   - Next cycle: IDLE, busy=0, eng_clr=1.
   - No out_valid and no done afterwards.
   - A new start then runs a full job identical to scenario 1.
4. start pulsed again during LOAD_I -> ignored; the job completes normally with 4 outputs.
5. Async rst asserted mid-LOAD_I, between clock edges.
   - All outputs go to 0 immediately, without waiting for a clock edge.
   - After release the controller sits in IDLE until start.
6. N=4, M=4, LAT=0 -> single out_valid, with (0,0), in the same cycle as the 16th image transfer; done the next cycle.
